// File: rtl/mc_array_ctrl_if.sv
// Request/response bundle between the inference controller and the array sequencer.
interface mc_array_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [5:0]  req_row_i;
  logic [63:0] req_col_mask_i;
  logic [63:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        busy_o;

  // Sequencer side
  modport slave (
    input  req_valid_i, req_we_i, req_row_i, req_col_mask_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o
  );

  // Requester side
  modport master (
    output req_valid_i, req_we_i, req_row_i, req_col_mask_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, busy_o
  );
endinterface

// File: rtl/mc_array_ctrl.sv
// Row write/read sequencer for the 64x64 2T2R memristor array macro.
module mc_array_ctrl #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned ARM_CYCLES   = 1,
  parameter int unsigned SENSE_CYCLES = 2,
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mc_array_ctrl_if.slave      bus,
  output logic [31:0]         CWLE,
  output logic [31:0]         CWLO,
  output logic [63:0]         CBLEN,
  output logic [63:0]         CBL,
  output logic [63:0]         CSL,
  output logic [63:0]         DIN,
  output logic [63:0]         DINb,
  input  logic [63:0]         DOUT
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ROW_W  = 6;
  localparam int unsigned COL_W  = 64;
  localparam int unsigned WL_W   = 32;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WL_SETUP   = 3'd1;
  localparam logic [2:0] S_PROG_A     = 3'd2;
  localparam logic [2:0] S_PROG_B     = 3'd3;
  localparam logic [2:0] S_READ_ARM   = 3'd4;
  localparam logic [2:0] S_READ_SENSE = 3'd5;
  localparam logic [2:0] S_WL_HOLD    = 3'd6;
  localparam logic [2:0] S_RESP       = 3'd7;

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARM_LD   = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] SENSE_LD = CNT_W'(SENSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] mask_q, mask_d;
  logic [COL_W-1:0] wdata_q, wdata_d;
  logic [COL_W-1:0] rdata_q, rdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic [WL_W-1:0]  cwle_q, cwle_d, cwlo_q, cwlo_d;
  logic [COL_W-1:0] cblen_q, cblen_d, cbl_q, cbl_d, csl_q, csl_d;
  logic [COL_W-1:0] din_q, din_d, dinb_q, dinb_d;
  logic             accept_c, cnt_done_c, wl_on_c;

  assign accept_c   = (state_q == S_IDLE) & bus.req_valid_i;
  assign cnt_done_c = (cnt_q == '0);

  // Next state, phase timer, request latch, and array waveforms decoded from the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    row_d       = row_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cwle_d      = '0;
    cwlo_d      = '0;
    cblen_d     = '0;
    cbl_d       = '0;
    csl_d       = '0;
    din_d       = '0;
    dinb_d      = '0;
    wl_on_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          we_d    = bus.req_we_i;
          row_d   = bus.req_row_i;
          mask_d  = bus.req_col_mask_i;
          wdata_d = bus.req_wdata_i;
          rdata_d = '0;
          cnt_d   = GUARD_LD;
          state_d = S_WL_SETUP;
        end
      end
      S_WL_SETUP: begin
        if (cnt_done_c) begin
          state_d = we_q ? S_PROG_A : S_READ_ARM;
          cnt_d   = we_q ? PULSE_LD : ARM_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PROG_A: begin
        if (cnt_done_c) begin
          state_d = S_PROG_B;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_PROG_B: begin
        if (cnt_done_c) begin
          state_d = S_WL_HOLD;
          cnt_d   = GUARD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_READ_ARM: begin
        if (cnt_done_c) begin
          state_d = S_READ_SENSE;
          cnt_d   = SENSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_READ_SENSE: begin
        if (cnt_done_c) begin
          // Sense amp output is active-low relative to the stored bit
          rdata_d = ~DOUT & mask_q;
          state_d = S_WL_HOLD;
          cnt_d   = GUARD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WL_HOLD: begin
        if (cnt_done_c) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
    wl_on_c     = (state_d != S_IDLE) && (state_d != S_RESP);

    if (wl_on_c) begin
      if (row_d[0]) cwle_d[row_d[ROW_W-1:1]] = 1'b1;
      else          cwlo_d[row_d[ROW_W-1:1]] = 1'b1;
    end

    case (state_d)
      S_PROG_A: begin
        cblen_d = mask_d;
        cbl_d   = ~wdata_d & mask_d;
      end
      S_PROG_B: begin
        cblen_d = mask_d;
        cbl_d   = ~wdata_d & mask_d;
        csl_d   = mask_d;
      end
      S_READ_ARM:   csl_d = '1;
      S_READ_SENSE: din_d = '1;
      default: ;
    endcase
  end

  // State, timer, latched request and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      row_q       <= '0;
      mask_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cwle_q      <= '0;
      cwlo_q      <= '0;
      cblen_q     <= '0;
      cbl_q       <= '0;
      csl_q       <= '0;
      din_q       <= '0;
      dinb_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      row_q       <= row_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      cwle_q      <= cwle_d;
      cwlo_q      <= cwlo_d;
      cblen_q     <= cblen_d;
      cbl_q       <= cbl_d;
      csl_q       <= csl_d;
      din_q       <= din_d;
      dinb_q      <= dinb_d;
    end
  end

  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.busy_o      = busy_q;
  assign CWLE            = cwle_q;
  assign CWLO            = cwlo_q;
  assign CBLEN           = cblen_q;
  assign CBL             = cbl_q;
  assign CSL             = csl_q;
  assign DIN             = din_q;
  assign DINb            = dinb_q;

endmodule

// File: tb/tb_mc_array_ctrl.sv
// Scoreboard bench for mc_array_ctrl with a cell-level array model driving DOUT.
module tb_mc_array_ctrl;
  localparam int G = 1;
  localparam int P = 4;
  localparam int A = 1;
  localparam int S = 2;
  localparam int WR_LAT = 2*G + 2*P;
  localparam int RD_LAT = 2*G + A + S;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cwle, cwlo;
  logic [63:0] cblen, cbl, csl, din, dinb;
  logic [63:0] dout = '0;

  mc_array_ctrl_if bus();

  mc_array_ctrl #(
    .PULSE_CYCLES(P), .ARM_CYCLES(A), .SENSE_CYCLES(S), .GUARD_CYCLES(G)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .CWLE(cwle), .CWLO(cwlo), .CBLEN(cblen), .CBL(cbl), .CSL(csl),
    .DIN(din), .DINb(dinb), .DOUT(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [5:0]  row;
    logic [63:0] mask;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          acc;
    int          stall;
  } op_t;

  op_t         exp_q[$];
  logic [63:0] ref_mem [64];
  logic [63:0] m0 [64];
  logic [63:0] m1 [64];
  int cyc = 0, total = 0, bad = 0, hs_cyc = -1, stall_left = 0, sense_n = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Cell-level array model: programs m0/m1 from pin levels, drives DOUT=m1 on the last sense cycle
  always @(negedge clk) begin
    int nwl, r;
    if (!rst_n) begin
      sense_n = 0;
    end else begin
      nwl = $countones({cwle, cwlo});
      r = 0;
      for (int i = 0; i < 32; i++) begin
        if (cwle[i]) r = 2*i + 1;
        if (cwlo[i]) r = 2*i;
      end
      if (nwl == 1) begin
        for (int c = 0; c < 64; c++) begin
          if (cblen[c]) begin
            case ({cbl[c], csl[c]})
              2'b00: m1[r][c] = 1'b0;
              2'b10: m0[r][c] = 1'b0;
              2'b01: m0[r][c] = 1'b1;
              default: m1[r][c] = 1'b1;
            endcase
          end
        end
        if (din == '1) sense_n++;
        else           sense_n = 0;
      end else begin
        sense_n = 0;
      end
      if (nwl == 1 && sense_n == S) dout = m1[r];
      else                          dout = {$urandom, $urandom};
    end
  end

  // Monitor: per-cycle pin expectations from the oldest accepted op, response pop on handshake
  always @(negedge clk) begin
    op_t         cur;
    int          k, lat;
    logic        act;
    logic [31:0] e_cwle, e_cwlo;
    logic [63:0] e_cblen, e_cbl, e_csl, e_din;
    logic        e_busy, e_rdy, e_rv;
    if (rst_n) begin
      act = 1'b0; k = 0; lat = 0;
      e_cwle = '0; e_cwlo = '0; e_cblen = '0; e_cbl = '0; e_csl = '0; e_din = '0;
      e_busy = 1'b0; e_rdy = 1'b1; e_rv = 1'b0;
      if (exp_q.size() > 0 && cyc >= exp_q[0].acc) begin
        act = 1'b1;
        cur = exp_q[0];
        k   = cyc - cur.acc;
        lat = cur.we ? WR_LAT : RD_LAT;
      end
      if (act) begin
        e_busy = 1'b1;
        e_rdy  = 1'b0;
        if (k < lat) begin
          if (cur.row[0]) e_cwle[cur.row[5:1]] = 1'b1;
          else            e_cwlo[cur.row[5:1]] = 1'b1;
          if (cur.we) begin
            if (k >= G && k < G + P) begin
              e_cblen = cur.mask; e_cbl = ~cur.wdata & cur.mask;
            end else if (k >= G + P && k < G + 2*P) begin
              e_cblen = cur.mask; e_cbl = ~cur.wdata & cur.mask; e_csl = cur.mask;
            end
          end else begin
            if (k >= G && k < G + A)              e_csl = '1;
            else if (k >= G + A && k < G + A + S) e_din = '1;
          end
        end else begin
          e_rv = 1'b1;
        end
      end
      chk("wl",  256'({cwle, cwlo}), 256'({e_cwle, e_cwlo}));
      chk("bl",  256'({cblen, cbl, csl}), 256'({e_cblen, e_cbl, e_csl}));
      chk("dl",  256'({din, dinb}), 256'({e_din, 64'd0}));
      chk("ctl", 256'({bus.busy_o, bus.req_ready_o, bus.rsp_valid_o}), 256'({e_busy, e_rdy, e_rv}));
      if (act && k >= lat) begin
        chk("rdata", 256'(bus.rsp_rdata_o), 256'(cur.rdata));
        if (k == lat) stall_left = cur.stall;
        if (stall_left > 0) begin
          bus.rsp_ready_i = 1'b0;
          stall_left--;
        end else begin
          bus.rsp_ready_i = 1'b1;
          void'(exp_q.pop_front());
          hs_cyc = cyc + 1;
        end
      end else begin
        bus.rsp_ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, record the word-level expectation
  task automatic issue(input logic we, input logic [5:0] row, input logic [63:0] mask,
                       input logic [63:0] wdata, input int stall, input logic chk_hs);
    op_t o;
    int  w;
    @(negedge clk);
    bus.req_we_i       = we;
    bus.req_row_i      = row;
    bus.req_col_mask_i = mask;
    bus.req_wdata_i    = wdata;
    bus.req_valid_i    = 1'b1;
    w = 0;
    while (!bus.req_ready_o && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready_o) begin
      total++; bad++;
      $display("FAIL accept_timeout cyc=%0d row=%0d", cyc, row);
    end else begin
      if (chk_hs) chk("rdy_after_hs", 256'(cyc), 256'(hs_cyc));
      o.we = we; o.row = row; o.mask = mask; o.wdata = wdata; o.stall = stall;
      o.rdata = we ? 64'd0 : (ref_mem[row] & mask);
      if (we) ref_mem[row] = (ref_mem[row] & ~mask) | (wdata & mask);
      o.acc = cyc + 1;
      exp_q.push_back(o);
    end
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout cyc=%0d pending=%0d", cyc, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [63:0] bits;
    int          w;
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_row_i      = '0;
    bus.req_col_mask_i = '0;
    bus.req_wdata_i    = '0;
    bus.rsp_ready_i    = 1'b1;
    for (int r = 0; r < 64; r++) begin
      bits = {$urandom, $urandom};
      m0[r] = bits; m1[r] = ~bits; ref_mem[r] = bits;
    end

    #1;
    chk("rst_wl",  256'({cwle, cwlo}), 256'(0));
    chk("rst_bl",  256'({cblen, cbl, csl}), 256'(0));
    chk("rst_ctl", 256'({din, dinb, bus.busy_o, bus.rsp_valid_o, bus.rsp_rdata_o}), 256'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed: full-row write then read back
    issue(1'b1, 6'd0, '1, 64'hA5A5_0000_FFFF_0001, 0, 1'b0);
    wait_idle();
    issue(1'b0, 6'd0, '1, 64'd0, 0, 1'b0);
    wait_idle();

    // Highest odd and even rows
    issue(1'b1, 6'd63, '1, {$urandom, $urandom}, 0, 1'b0);
    issue(1'b0, 6'd62, '1, 64'd0, 0, 1'b0);
    issue(1'b0, 6'd63, '1, 64'd0, 1, 1'b0);
    wait_idle();

    // Partial mask write, then other columns and full row
    issue(1'b1, 6'd7, 64'h0000_0000_0000_00F0, {$urandom, $urandom}, 0, 1'b0);
    issue(1'b0, 6'd7, ~64'h0000_0000_0000_00F0, 64'd0, 0, 1'b0);
    issue(1'b0, 6'd7, '1, 64'd0, 0, 1'b0);
    issue(1'b0, 6'd7, 64'd0, 64'd0, 0, 1'b0);
    issue(1'b1, 6'd9, 64'd0, '1, 0, 1'b0);
    issue(1'b0, 6'd9, '1, 64'd0, 0, 1'b0);
    wait_idle();

    // Response back-pressure with the next request already waiting
    issue(1'b0, 6'd0, '1, 64'd0, 6, 1'b0);
    issue(1'b0, 6'd63, '1, 64'd0, 0, 1'b1);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [63:0] mk;
      case ($urandom_range(0, 5))
        0:       mk = 64'd0;
        1:       mk = '1;
        default: mk = {$urandom, $urandom};
      endcase
      issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), mk,
            {$urandom, $urandom}, int'($urandom_range(0, 3)), 1'b0);
    end
    wait_idle();

    // Asynchronous reset in the middle of the second programming phase
    issue(1'b1, 6'd21, '1, {$urandom, $urandom}, 0, 1'b0);
    w = 0;
    while (exp_q.size() > 0 && (cyc - exp_q[0].acc) < G + P + 1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("in_prog_b", 256'(csl), 256'({64{1'b1}}));
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_wl",  256'({cwle, cwlo}), 256'(0));
    chk("abort_bl",  256'({cblen, cbl, csl}), 256'(0));
    chk("abort_ctl", 256'({din, dinb, bus.busy_o, bus.rsp_valid_o, bus.rsp_rdata_o}), 256'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 256'(bus.req_ready_o), 256'(1));
    repeat (15) @(negedge clk);

    // Resynchronise the aborted row and finish with a few more reads
    issue(1'b1, 6'd21, '1, {$urandom, $urandom}, 0, 1'b0);
    issue(1'b0, 6'd21, '1, 64'd0, 0, 1'b0);
    issue(1'b0, 6'd0, '1, 64'd0, 0, 1'b0);
    issue(1'b0, 6'd7, '1, 64'd0, 2, 1'b0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
